mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_MAX, default 8, giving the maximum number of consecutive cycles one requester may own the mux; legal range 1..15.
REQ-002 The module SHALL have parameter CNT_W, default 4, giving the hold-counter width; HOLD_MAX SHALL be at most 2^CNT_W-1.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port req, input, 4 bits: level request, where bit n is requester n asking for mux input i[n].
REQ-006 The module SHALL have port gnt, output, 4 bits: registered one-hot grant, or all zero when there is no owner.
REQ-007 The module SHALL have port s, output, 2 bits: registered 4:1 mux select equal to the index of the current or last owner.
REQ-008 The module SHALL have port busy, output, 1 bit: registered flag, high while any gnt bit is high.
REQ-009 The module SHALL have port timeout, output, 1 bit: registered one-cycle pulse marking a forced release.

Function
REQ-010 The module SHALL implement a two-state FSM with states IDLE and GRANT, plus a 2-bit last-owner pointer (ptr) and a CNT_W-bit hold counter (cnt).
REQ-011 In IDLE with req==0, the module SHALL stay in IDLE and hold gnt=0, with s and ptr unchanged.
REQ-012 In IDLE with req!=0, the module SHALL select the first set req bit scanning upward from ptr+1 modulo 4, wrapping 3->0.
REQ-013 On that edge the module SHALL register gnt=onehot(winner), s=winner, busy=1 and cnt=1, and move to GRANT; the grant is visible one cycle after req is first sampled.
REQ-014 In GRANT with req[s]=1 and cnt<HOLD_MAX, the module SHALL hold gnt and s and increment cnt.
REQ-015 In GRANT with req[s]=0 (voluntary release), the module SHALL, on the next edge, set gnt=0, busy=0, ptr=s and go to IDLE, with s unchanged.
REQ-016 In GRANT with req[s]=1 and cnt==HOLD_MAX (forced release), the module SHALL behave as in REQ-015 and additionally pulse timeout=1 for exactly that one cycle.
REQ-017 Every release SHALL be followed by at least one IDLE cycle with gnt=0 before any new grant (dead cycle for mux settling), so consecutive grants are separated by exactly one cycle when requests are pending.
REQ-018 The rotation rule SHALL guarantee that, with all four requesters continuously requesting, grants go 0,1,2,3,0,... and each requester waits at most 3 ownership periods plus 3 dead cycles.
REQ-019 The module SHALL ignore changes on req bits other than req[s] during GRANT; only the IDLE scan samples them.
REQ-020 gnt SHALL never have more than one bit set, busy SHALL equal |gnt at all times, and cnt SHALL saturate (never wrap) and is don't-care in IDLE.
REQ-021 If the owner drops req in the same cycle that cnt reaches HOLD_MAX, the module SHALL treat it as a voluntary release with timeout=0.
REQ-022 With HOLD_MAX=1, each grant SHALL last exactly one cycle, with timeout pulsed if req[s] is still high.

Reset
REQ-023 While rst_n=0, the module SHALL immediately, regardless of clk, force state=IDLE, gnt=0, s=0, busy=0, timeout=0, cnt=0 and ptr=3, so requester 0 has top priority after reset.
REQ-024 Reset asserted mid-GRANT SHALL abort the grant with no timeout pulse.
REQ-025 The first rising edge after rst_n deasserts SHALL be able to perform a grant if req!=0.

Verification
REQ-026 Reset, then req=4'b0000 for 5 cycles -> the bench SHALL check gnt=0, s=0 and busy=0 throughout.
REQ-027 From reset, req=4'b1111 held -> the bench SHALL check that grants go 0,1,2,3,0, each lasting 8 cycles with a timeout pulse, separated by one gnt=0 cycle.
REQ-028 req=4'b0100 for 3 cycles, then 0 -> the bench SHALL check gnt=4'b0100 and s=2 for 3 cycles, then gnt=0, timeout=0, with s staying 2.
REQ-029 Owner 1 releases while req=4'b1001 -> the bench SHALL check that the next grant goes to 3, not 0.
REQ-030 rst_n pulled low 4 cycles into a grant to requester 2 -> the bench SHALL check gnt=0 and s=0 immediately, and that the first grant after release of reset goes to requester 0 when req=4'b0101.
REQ-031 In the HOLD_MAX=1 build with req=4'b0011 held -> the bench SHALL check one-cycle grants alternating 0,1 with a dead cycle between each and timeout high on every release.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Purpose: bundles the request/grant/select signals of the 4-way round-robin mux arbiter.
// Latency: none; wires only.
// Backpressure: none; req is a level request, the arbiter answers with gnt/s/busy/timeout.
// Ports: req[3:0] requester levels; gnt[3:0] one-hot grant; s[1:0] mux select;
//        busy = any grant; timeout = one-cycle forced-release pulse.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       busy;
  logic       timeout;

  // Requester side: drives the request levels, observes the arbiter outputs.
  modport master (
    output req,
    input  gnt,
    input  s,
    input  busy,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output s,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Purpose: round-robin arbiter owning a 4:1 mux select, with a bounded hold time per owner.
// Latency: grant registered one cycle after req is sampled; one dead cycle between owners.
// Backpressure: none; the owner keeps the mux while req[s] stays high, up to HOLD_MAX cycles.
// Ports: clk (rising edge), rst_n (async active-low), bus (slave modport: req in;
//        gnt, s, busy, timeout out, all registered).
// HOLD_MAX is legal in 1..15 and must fit in CNT_W bits (HOLD_MAX <= 2^CNT_W-1).
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_rr_arbiter_if.slave     bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         s_q, s_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ptr_q, ptr_d;

  // Round-robin scan: first set req bit starting just above the last owner.
  logic [1:0]         winner;
  logic               found;
  logic [1:0]         idx;

  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          s_d     = winner;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end

      GRANT: begin
        // The owner's own request is checked first so that dropping req on the
        // same cycle the hold limit is reached counts as a voluntary release.
        if (!bus.req[s_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = s_q;
        end else if (cnt_q >= CNT_W'(HOLD_MAX)) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = s_q;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ptr resets to 3 so requester 0 is scanned first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      s_q       <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s       = s_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Purpose: self-checking bench for mux_rr_arbiter, HOLD_MAX=8 and HOLD_MAX=1 builds side by side.
// Latency: each vector drives req at the falling edge and expects the outputs after the next rising edge.
// Backpressure: n/a; the requester side of each interface is driven directly.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_rr_arbiter_if bus_a();
  mux_rr_arbiter_if bus_b();

  mux_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  mux_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int         grp;
    logic       sel;      // 0: HOLD_MAX=8 build, 1: HOLD_MAX=1 build
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         chk_cnt;
  int         pass_cnt;

  function automatic string grp_name(input int g);
    case (g)
      0:       return "idle";
      1:       return "rotate";
      2:       return "vol_release";
      3:       return "skip_to_3";
      4:       return "drop_at_limit";
      5:       return "hold1";
      default: return "hand";
    endcase
  endfunction

  function automatic void add(input int g, input logic sel, input logic [3:0] rq,
                              input logic [3:0] gn, input logic [1:0] sv,
                              input logic b, input logic to);
    vec_t v;
    v.grp = g; v.sel = sel; v.req = rq; v.gnt = gn; v.s = sv; v.busy = b; v.timeout = to;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] obs(input logic sel);
    if (sel) return {bus_b.gnt, bus_b.s, bus_b.busy, bus_b.timeout};
    return {bus_a.gnt, bus_a.s, bus_a.busy, bus_a.timeout};
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got gnt=%b s=%0d busy=%b timeout=%b, want gnt=%b s=%0d busy=%b timeout=%b",
                  name, idx, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [7:0] e;
    @(negedge clk);
    if (v.sel) bus_b.req = v.req;
    else       bus_a.req = v.req;
    exp_q.push_back({v.gnt, v.s, v.busy, v.timeout});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(grp_name(v.grp), idx, obs(v.sel), e);
  endtask

  // Watchdog: the run is a fixed number of cycles, this only guards against a stall.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    chk_cnt  = 0;
    pass_cnt = 0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) add(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // All requesting: 0,1,2,3,0, each 8 cycles then a dead cycle with timeout.
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) add(1, 1'b0, 4'b1111, 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
      add(1, 1'b0, 4'b1111, 4'b0000, 2'(g % 4), 1'b0, 1'b1);
    end
    add(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Voluntary release by requester 2; s stays 2.
    for (int i = 0; i < 3; i++) add(2, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(2, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(2, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    // Owner 1 ignores other bits, then releases while 0 and 3 wait: 3 wins.
    add(3, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(3, 1'b0, 4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(3, 1'b0, 4'b1001, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(3, 1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(3, 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    // Owner drops req on the cycle its count reaches the limit: no timeout.
    for (int i = 0; i < 8; i++) add(4, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // HOLD_MAX=1 build: one-cycle grants alternating 0,1 with timeout on each release.
    for (int k = 0; k < 4; k++) begin
      add(5, 1'b1, 4'b0011, 4'(1 << (k % 2)), 2'(k % 2), 1'b1, 1'b0);
      add(5, 1'b1, 4'b0011, 4'b0000, 2'(k % 2), 1'b0, 1'b1);
    end
    add(5, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Reset.
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 0, obs(1'b0), 8'h00);
    check("reset_b", 0, obs(1'b1), 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset in the middle of a grant to requester 2.
    v.grp = 6; v.sel = 1'b0; v.req = 4'b0100; v.gnt = 4'b0100; v.s = 2'd2; v.busy = 1'b1; v.timeout = 1'b0;
    for (int i = 0; i < 4; i++) step(v, i);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async", 0, obs(1'b0), 8'h00);
    bus_a.req = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", 0, obs(1'b0), 8'h00);
    rst_n = 1'b1;
    v.req = 4'b0101; v.gnt = 4'b0001; v.s = 2'd0; v.busy = 1'b1; v.timeout = 1'b0;
    step(v, 4);
    v.req = 4'b0000; v.gnt = 4'b0000; v.s = 2'd0; v.busy = 1'b0; v.timeout = 1'b0;
    step(v, 5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
